// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter slice.
package dmem_arbiter_pkg;

   localparam int unsigned DEF_ISIZE = 16;
   localparam int unsigned DEF_DSIZE = 16;

   typedef enum logic [1:0] {
      DMA_IDLE   = 2'd0,
      DMA_ACCESS = 2'd1,
      DMA_RESP   = 2'd2
   } dmaState_t;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_t;

   // The round-robin pointer always moves to whichever port did not win.
   function automatic port_t otherPort(input port_t p);
      return (p == PORT_A) ? PORT_B : PORT_A;
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-input round-robin picker. Bit 0 is port A, bit 1 is port B.
// The mask hides a port whose request still shows an already-completed command.
module rr_arb2
   import dmem_arbiter_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic [1:0] i_mask,
   input  port_t      i_ptr,
   output port_t      o_gnt,
   output logic       o_any
);

   logic [1:0] w_elig;

   // Favoured port wins a tie; a lone eligible requester wins regardless of the pointer.
   always_comb begin
      w_elig = i_req & ~i_mask;
      o_any  = |w_elig;
      o_gnt  = PORT_A;
      if (w_elig == 2'b11) begin
         o_gnt = i_ptr;
      end else if (w_elig[1]) begin
         o_gnt = PORT_B;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the single-port data memory.
// Port A is the CPU MEM stage, port B the debug/DMA loader. A granted command is
// latched, driven to memory for one ACCESS cycle, then acked (registered) in RESP.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 65536,
   parameter int unsigned ISIZE     = DEF_ISIZE,
   parameter int unsigned DSIZE     = DEF_DSIZE
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             a_req,
   input  logic             a_wen,
   input  logic [ISIZE-1:0] a_addr,
   input  logic [DSIZE-1:0] a_wdata,
   output logic             a_ack,
   output logic             a_err,
   output logic [DSIZE-1:0] a_rdata,
   input  logic             b_req,
   input  logic             b_wen,
   input  logic [ISIZE-1:0] b_addr,
   input  logic [DSIZE-1:0] b_wdata,
   output logic             b_ack,
   output logic             b_err,
   output logic [DSIZE-1:0] b_rdata,
   output logic             mem_wen,
   output logic             mem_ren,
   output logic [ISIZE-1:0] mem_addr,
   output logic [DSIZE-1:0] mem_wdata,
   input  logic [DSIZE-1:0] mem_rdata,
   output logic             busy
);

   dmaState_t        r_state, w_nextState;
   port_t            r_ptr, r_owner, w_gnt;
   logic             w_any, w_load, w_access;
   logic [1:0]       w_mask;

   logic [ISIZE-1:0] r_addr, w_winAddr;
   logic [DSIZE-1:0] r_wdata, w_winWdata;
   logic             r_wen, r_err, w_winWen, w_winErr;

   logic             r_aAck, r_aErr, r_bAck, r_bErr;
   logic [DSIZE-1:0] r_aRdata, r_bRdata;

   rr_arb2 u_arb (
      .i_req  ({b_req, a_req}),
      .i_mask (w_mask),
      .i_ptr  (r_ptr),
      .o_gnt  (w_gnt),
      .o_any  (w_any)
   );

   // Next-state logic: arbitrate from IDLE, or from RESP with the just-acked port masked
   // so its still-raised request cannot trigger a duplicate access.
   always_comb begin
      w_nextState = r_state;
      w_load      = 1'b0;
      w_mask      = 2'b00;
      case (r_state)
         DMA_IDLE: begin
            if (w_any) begin
               w_load      = 1'b1;
               w_nextState = DMA_ACCESS;
            end
         end
         DMA_ACCESS: begin
            w_nextState = DMA_RESP;
         end
         DMA_RESP: begin
            w_mask = (r_owner == PORT_A) ? 2'b01 : 2'b10;
            if (w_any) begin
               w_load      = 1'b1;
               w_nextState = DMA_ACCESS;
            end else begin
               w_nextState = DMA_IDLE;
            end
         end
         default: begin
            w_nextState = DMA_IDLE;
         end
      endcase
   end

   // Select the winner's command and range-check its address (unsigned, zero-extended).
   always_comb begin
      w_winAddr  = (w_gnt == PORT_B) ? b_addr  : a_addr;
      w_winWdata = (w_gnt == PORT_B) ? b_wdata : a_wdata;
      w_winWen   = (w_gnt == PORT_B) ? b_wen   : a_wen;
      w_winErr   = (32'(w_winAddr) >= 32'(MEM_WORDS));
   end

   // State register, round-robin pointer and command latches, loaded on every grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= DMA_IDLE;
         r_ptr   <= PORT_A;
         r_owner <= PORT_A;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wen   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_load) begin
            r_owner <= w_gnt;
            r_ptr   <= otherPort(w_gnt);
            r_addr  <= w_winAddr;
            r_wdata <= w_winWdata;
            r_wen   <= w_winWen;
            r_err   <= w_winErr;
         end
      end
   end

   // Registered response: set for the owner at the end of ACCESS, cleared in every other cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_aAck   <= 1'b0;
         r_aErr   <= 1'b0;
         r_aRdata <= '0;
         r_bAck   <= 1'b0;
         r_bErr   <= 1'b0;
         r_bRdata <= '0;
      end else begin
         r_aAck   <= 1'b0;
         r_aErr   <= 1'b0;
         r_aRdata <= '0;
         r_bAck   <= 1'b0;
         r_bErr   <= 1'b0;
         r_bRdata <= '0;
         if (w_access) begin
            if (r_owner == PORT_A) begin
               r_aAck   <= 1'b1;
               r_aErr   <= r_err;
               r_aRdata <= (r_err | r_wen) ? '0 : mem_rdata;
            end else begin
               r_bAck   <= 1'b1;
               r_bErr   <= r_err;
               r_bRdata <= (r_err | r_wen) ? '0 : mem_rdata;
            end
         end
      end
   end

   // Memory strobes only in ACCESS, never for an out-of-range command, and never during reset.
   always_comb begin
      w_access  = (r_state == DMA_ACCESS);
      mem_wen   = ~rst & w_access &  r_wen & ~r_err;
      mem_ren   = ~rst & w_access & ~r_wen & ~r_err;
      mem_addr  = r_addr;
      mem_wdata = r_wdata;
      busy      = (r_state != DMA_IDLE);
   end

   assign a_ack   = r_aAck;
   assign a_err   = r_aErr;
   assign a_rdata = r_aRdata;
   assign b_ack   = r_bAck;
   assign b_err   = r_bErr;
   assign b_rdata = r_bRdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 256-word combinational-read memory model.
module tb_dmem_arbiter;

   logic        clk;
   logic        rst;
   logic        aReq, aWen, aAck, aErr;
   logic [15:0] aAddr, aWdata, aRdata;
   logic        bReq, bWen, bAck, bErr;
   logic [15:0] bAddr, bWdata, bRdata;
   logic        memWen, memRen, busy;
   logic [15:0] memAddr, memWdata, memRdata;

   logic [15:0] mem [0:255];

   int checkCount = 0;
   int failCount  = 0;
   int acksA, acksB;
   logic expA;

   dmem_arbiter #(
      .MEM_WORDS (256),
      .ISIZE     (16),
      .DSIZE     (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .a_req     (aReq),
      .a_wen     (aWen),
      .a_addr    (aAddr),
      .a_wdata   (aWdata),
      .a_ack     (aAck),
      .a_err     (aErr),
      .a_rdata   (aRdata),
      .b_req     (bReq),
      .b_wen     (bWen),
      .b_addr    (bAddr),
      .b_wdata   (bWdata),
      .b_ack     (bAck),
      .b_err     (bErr),
      .b_rdata   (bRdata),
      .mem_wen   (memWen),
      .mem_ren   (memRen),
      .mem_addr  (memAddr),
      .mem_wdata (memWdata),
      .mem_rdata (memRdata),
      .busy      (busy)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory model: write at the clock edge, combinational read.
   always @(posedge clk) begin
      if (memWen) mem[memAddr[7:0]] <= memWdata;
   end
   assign memRdata = mem[memAddr[7:0]];

   // Hard stop if the directed sequence somehow stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic port, input logic req, input logic wen,
                                input logic [15:0] addr, input logic [15:0] wdata);
      if (port == 1'b0) begin
         aReq = req; aWen = wen; aAddr = addr; aWdata = wdata;
      end else begin
         bReq = req; bWen = wen; bAddr = addr; bWdata = wdata;
      end
   endtask

   // Leaves the bench at a falling edge with rst still high and both ports idle.
   task automatic resetDut();
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      for (int i = 0; i < 256; i++) mem[i] = 16'h0;

      // 1: single A read, latency and reset values
      resetDut();
      mem[8'h10] = 16'hBEEF;
      checkOutput("rst_busy",   32'(busy),   32'd0);
      checkOutput("rst_aAck",   32'(aAck),   32'd0);
      checkOutput("rst_bAck",   32'(bAck),   32'd0);
      checkOutput("rst_aRdata", 32'(aRdata), 32'd0);
      checkOutput("rst_memWen", 32'(memWen), 32'd0);
      checkOutput("rst_memRen", 32'(memRen), 32'd0);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
      @(negedge clk);
      checkOutput("t1_ren_access", 32'(memRen),  32'd1);
      checkOutput("t1_addr",       32'(memAddr), 32'h10);
      checkOutput("t1_noack_early",32'(aAck),    32'd0);
      checkOutput("t1_busy",       32'(busy),    32'd1);
      @(negedge clk);
      checkOutput("t1_ren_resp",   32'(memRen),  32'd0);
      checkOutput("t1_aAck",       32'(aAck),    32'd1);
      checkOutput("t1_aRdata",     32'(aRdata),  32'hBEEF);
      checkOutput("t1_aErr",       32'(aErr),    32'd0);
      checkOutput("t1_bAck",       32'(bAck),    32'd0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      checkOutput("t1_ack_clear",  32'(aAck),    32'd0);
      checkOutput("t1_rdata_clear",32'(aRdata),  32'd0);
      checkOutput("t1_idle",       32'(busy),    32'd0);

      // 2: simultaneous A write / B read of the same word
      resetDut();
      mem[8'h04] = 16'h0;
      rst = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0004, 16'h1234);
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0004, 16'h0);
      @(negedge clk);
      checkOutput("t2_wenA",   32'(memWen),   32'd1);
      checkOutput("t2_renA",   32'(memRen),   32'd0);
      checkOutput("t2_wdataA", 32'(memWdata), 32'h1234);
      @(negedge clk);
      checkOutput("t2_aAck",   32'(aAck),     32'd1);
      checkOutput("t2_aRdata", 32'(aRdata),   32'd0);
      checkOutput("t2_bAck0",  32'(bAck),     32'd0);
      checkOutput("t2_memWr",  32'(mem[8'h04]), 32'h1234);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      checkOutput("t2_renB",   32'(memRen),   32'd1);
      checkOutput("t2_aAck0",  32'(aAck),     32'd0);
      @(negedge clk);
      checkOutput("t2_bAck",   32'(bAck),     32'd1);
      checkOutput("t2_bRdata", 32'(bRdata),   32'h1234);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      checkOutput("t2_idle",   32'(busy),     32'd0);

      // 3: both ports hold requests, grants alternate A,B,A,B
      resetDut();
      mem[8'h30] = 16'h1111;
      mem[8'h31] = 16'h2222;
      rst = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0031, 16'h0);
      acksA = 0;
      acksB = 0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (aAck) acksA++;
         if (bAck) acksB++;
         if (k % 2 == 0) begin
            expA = ((k / 2) % 2 == 1);
            checkOutput("t3_aAck", 32'(aAck), 32'(expA));
            checkOutput("t3_bAck", 32'(bAck), 32'(!expA));
            if (expA) checkOutput("t3_aRdata", 32'(aRdata), 32'h1111);
            else      checkOutput("t3_bRdata", 32'(bRdata), 32'h2222);
         end else begin
            checkOutput("t3_ren",  32'(memRen),  32'd1);
            checkOutput("t3_addr", 32'(memAddr), (((k + 1) / 2) % 2 == 1) ? 32'h30 : 32'h31);
         end
         if (k == 16) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
         end
      end
      checkOutput("t3_acksA", 32'(acksA), 32'd4);
      checkOutput("t3_acksB", 32'(acksB), 32'd4);
      @(negedge clk);
      checkOutput("t3_idle",  32'(busy),  32'd0);

      // 4: out-of-range B write is blocked and acked with err
      resetDut();
      mem[8'h00] = 16'hA5A5;
      rst = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h0100, 16'hFFFF);
      @(negedge clk);
      checkOutput("t4_wen",    32'(memWen), 32'd0);
      checkOutput("t4_ren",    32'(memRen), 32'd0);
      checkOutput("t4_busy",   32'(busy),   32'd1);
      @(negedge clk);
      checkOutput("t4_bAck",   32'(bAck),   32'd1);
      checkOutput("t4_bErr",   32'(bErr),   32'd1);
      checkOutput("t4_bRdata", 32'(bRdata), 32'd0);
      checkOutput("t4_aAck",   32'(aAck),   32'd0);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      checkOutput("t4_mem0",   32'(mem[8'h00]), 32'hA5A5);
      checkOutput("t4_errClr", 32'(bErr),   32'd0);

      // 5: reset during A's write ACCESS drops the access
      resetDut();
      mem[8'h20] = 16'h0BAD;
      rst = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0020, 16'h5555);
      @(negedge clk);
      checkOutput("t5_wenBefore", 32'(memWen), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("t5_wenForced", 32'(memWen), 32'd0);
      @(negedge clk);
      checkOutput("t5_aAck",  32'(aAck),  32'd0);
      checkOutput("t5_busy",  32'(busy),  32'd0);
      checkOutput("t5_wen",   32'(memWen),32'd0);
      checkOutput("t5_mem",   32'(mem[8'h20]), 32'h0BAD);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      checkOutput("t5_aAckLater", 32'(aAck), 32'd0);

      // 6: A alone, back-to-back reads, acks three cycles apart
      resetDut();
      mem[8'h40] = 16'h4040;
      mem[8'h41] = 16'h4141;
      rst = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0);
      @(negedge clk);
      checkOutput("t6_ren1",   32'(memRen), 32'd1);
      @(negedge clk);
      checkOutput("t6_ack1",   32'(aAck),   32'd1);
      checkOutput("t6_rdata1", 32'(aRdata), 32'h4040);
      @(negedge clk);
      checkOutput("t6_noDup",  32'(busy),   32'd0);
      checkOutput("t6_noRen",  32'(memRen), 32'd0);
      checkOutput("t6_gap",    32'(aAck),   32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0041, 16'h0);
      @(negedge clk);
      checkOutput("t6_ren2",   32'(memRen), 32'd1);
      checkOutput("t6_addr2",  32'(memAddr),32'h41);
      @(negedge clk);
      checkOutput("t6_ack2",   32'(aAck),   32'd1);
      checkOutput("t6_rdata2", 32'(aRdata), 32'h4141);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      checkOutput("t6_idle",   32'(busy),   32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
